m1crypto_stream: RTL

M1CRYPTO_STREAM -- requirements
Module: m1crypto_stream

---
 rtl/m1crypto_stream.sv | 136 +++++++++++++
 1 files changed

// File: rtl/m1crypto_stream.sv
// Bit-serial 48-bit LFSR stream cipher: one LFSR step per cycle, DATA_W steps per word,
// with keystream, feedback and encrypt modes selected per word.
module m1crypto_stream #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              sysclk,
  input  logic              resetn,
  input  logic [47:0]       key,
  input  logic              load_key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [47:0]       lfsr_state
);

  localparam int unsigned CntW    = $clog2(DATA_W + 1);
  localparam logic [15:0] FA      = 16'h9E98;
  localparam logic [15:0] FB      = 16'hB48E;
  localparam logic [31:0] FC      = 32'hEC57E80A;
  // Feedback taps 0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43
  localparam logic [47:0] TapMask = 48'h0E882B0AD621;

  localparam logic [1:0] ModeKs      = 2'd0;
  localparam logic [1:0] ModeFeed    = 2'd1;
  localparam logic [1:0] ModeFeedEnc = 2'd2;
  localparam logic [1:0] ModeEnc     = 2'd3;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [47:0]       lfsr_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] res_q, res_d;

  logic [3:0] n4, n3, n2, n1, n0;
  logic [4:0] f_idx;
  logic       ks, lf, d_bit, nb, res_bit, last_step, accept;

  assign n4    = {lfsr_q[47], lfsr_q[45], lfsr_q[43], lfsr_q[41]};
  assign n3    = {lfsr_q[39], lfsr_q[37], lfsr_q[35], lfsr_q[33]};
  assign n2    = {lfsr_q[31], lfsr_q[29], lfsr_q[27], lfsr_q[25]};
  assign n1    = {lfsr_q[23], lfsr_q[21], lfsr_q[19], lfsr_q[17]};
  assign n0    = {lfsr_q[15], lfsr_q[13], lfsr_q[11], lfsr_q[9]};
  assign f_idx = {FA[n4], FB[n3], FA[n2], FA[n1], FB[n0]};
  assign ks    = FC[f_idx];
  assign lf    = ^(lfsr_q & TapMask);

  assign last_step = (cnt_q == CntW'(DATA_W - 1));
  assign accept    = in_valid && in_ready;

  // Counter is wider than a bit index, so select the data bit by comparison.
  always_comb begin
    d_bit = 1'b0;
    res_d = res_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt_q == CntW'(i)) begin
        d_bit    = data_q[i];
        res_d[i] = res_bit;
      end
    end
  end

  always_comb begin
    nb      = lf;
    res_bit = ks;
    unique case (mode_q)
      ModeKs:      begin nb = lf;                 res_bit = ks;         end
      ModeFeed:    begin nb = lf ^ d_bit;         res_bit = ks;         end
      ModeFeedEnc: begin nb = lf ^ d_bit ^ ks;    res_bit = d_bit ^ ks; end
      ModeEnc:     begin nb = lf;                 res_bit = d_bit ^ ks; end
      default:     begin nb = lf;                 res_bit = ks;         end
    endcase
  end

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_key) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (accept)    state_d = StShift;
        StShift: if (last_step) state_d = StDone;
        StDone:  if (out_ready) state_d = StIdle;
        default:                state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle) && !load_key;
    out_valid = (state_q == StDone);
    busy      = (state_q == StShift) || (state_q == StDone);
  end

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      mode_q <= '0;
      res_q  <= '0;
    end else begin
      if (load_key) begin
        lfsr_q <= {key[7:0], key[15:8], key[23:16], key[31:24], key[39:32], key[47:40]};
      end else if (state_q == StShift) begin
        lfsr_q <= {nb, lfsr_q[47:1]};
        cnt_q  <= cnt_q + CntW'(1);
        res_q  <= res_d;
      end
      if (accept) begin
        data_q <= in_data;
        mode_q <= in_mode;
        cnt_q  <= '0;
      end
    end
  end

  assign out_data   = res_q;
  assign lfsr_state = lfsr_q;

endmodule
